// File: rtl/fcart_reg_pkg.sv
// Shared register-channel definitions for the SPI bridge and the mapper mux.
package fcart_reg_pkg;
    localparam logic [3:0] REG_MAPPER = 4'd0;
    localparam logic [3:0] REG_LOADER = 4'd1;
    localparam int         CMD_RW_BIT = 7;
    localparam logic [7:0] CRC8_POLY  = 8'h07;

    typedef enum logic [2:0] {IDLE, CMD, DATA, CRC, DONE} spi_state_t;

    // One MSB-first CRC-8 step for a single serial bit.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
        return {crc[6:0], 1'b0} ^ ((crc[7] ^ b) ? CRC8_POLY : 8'h00);
    endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// Synchronizer chain for one SPI pin with rise/fall pulses taken from its last two stages.
module spi_sync_edge #(
    parameter int STAGES  = 3,
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic cpu_reset,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);
    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge cpu_reset) begin
        if (cpu_reset) sync_q <= {STAGES{RST_VAL}};
        else           sync_q <= {sync_q[STAGES-2:0], d_i};
    end

    // sync_q[STAGES-2] is the newer sample, sync_q[STAGES-1] the older one.
    assign rise_o =  sync_q[STAGES-2] & ~sync_q[STAGES-1];
    assign fall_o = ~sync_q[STAGES-2] &  sync_q[STAGES-1];
endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave feeding the register-write channel, fully oversampled in clk.
// Define SPI_REG_CRC_EN to add a trailing CRC-8 byte to every frame.
module spi_reg_bridge
    import fcart_reg_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 3
) (
    input  logic              clk,
    input  logic              cpu_reset,
    input  logic              spi_sck,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] wr_reg,
    output logic [ADDR_W-1:0] wr_reg_addr,
    output logic              wr_reg_changed,
    output logic              frame_err
);
    localparam int               CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] BYTE_END = CNT_W'(7);

    logic sck_rise, sck_fall, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic mosi_s;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
        .clk(clk), .cpu_reset(cpu_reset), .d_i(spi_sck), .rise_o(sck_rise), .fall_o(sck_fall));
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk(clk), .cpu_reset(cpu_reset), .d_i(spi_cs_n), .rise_o(cs_rise), .fall_o(cs_fall));

    // MOSI lags sck by one stage; it is stable for >=4 clk around each rise.
    always_ff @(posedge clk or posedge cpu_reset) begin
        if (cpu_reset) mosi_q <= '0;
        else           mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
    end
    assign mosi_s = mosi_q[SYNC_STAGES-1];

    spi_state_t        state_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [6:0]        cmd_q;
    logic              rw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] wr_reg_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic              chg_q, miso_q, oe_q, ferr_q;
`ifdef SPI_REG_CRC_EN
    logic [7:0]        crc_q;
    logic [6:0]        crc_rx_q;
`endif

    always_ff @(posedge clk or posedge cpu_reset) begin
        if (cpu_reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            cmd_q     <= '0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            shift_q   <= '0;
            wr_reg_q  <= '0;
            wr_addr_q <= '0;
            chg_q     <= 1'b0;
            miso_q    <= 1'b0;
            oe_q      <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef SPI_REG_CRC_EN
            crc_q     <= '0;
            crc_rx_q  <= '0;
`endif
        end else begin
            ferr_q <= 1'b0;
            if (cs_fall) begin
                // Also the restart path for a chip-select glitch mid-frame.
                state_q   <= CMD;
                bit_cnt_q <= '0;
                miso_q    <= 1'b0;
                oe_q      <= 1'b1;
`ifdef SPI_REG_CRC_EN
                crc_q     <= '0;
`endif
            end else if (cs_rise) begin
                if (state_q == CMD || state_q == DATA || state_q == CRC) ferr_q <= 1'b1;
                state_q <= IDLE;
                miso_q  <= 1'b0;
                oe_q    <= 1'b0;
            end else begin
                case (state_q)
                    CMD: if (sck_rise) begin
                        cmd_q     <= {cmd_q[5:0], mosi_s};
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
`ifdef SPI_REG_CRC_EN
                        crc_q     <= crc8_step(crc_q, mosi_s);
`endif
                        if (bit_cnt_q == BYTE_END) begin
                            bit_cnt_q <= '0;
                            state_q   <= DATA;
                            rw_q      <= cmd_q[CMD_RW_BIT-1];
                            addr_q    <= {cmd_q[ADDR_W-2:0], mosi_s};
                            if (cmd_q[CMD_RW_BIT-1]) shift_q <= rd_data;
                        end
                    end
                    DATA: if (sck_rise) begin
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        if (!rw_q) begin
                            shift_q <= {shift_q[DATA_W-2:0], mosi_s};
`ifdef SPI_REG_CRC_EN
                            crc_q   <= crc8_step(crc_q, mosi_s);
`endif
                        end
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_q <= '0;
`ifdef SPI_REG_CRC_EN
                            state_q   <= CRC;
`else
                            state_q   <= DONE;
                            if (!rw_q) begin
                                wr_reg_q  <= {shift_q[DATA_W-2:0], mosi_s};
                                wr_addr_q <= addr_q;
                                chg_q     <= ~chg_q;
                            end
`endif
                        end
                    end else if (sck_fall && rw_q) begin
                        miso_q  <= shift_q[DATA_W-1];
                        shift_q <= {shift_q[DATA_W-2:0], 1'b0};
`ifdef SPI_REG_CRC_EN
                        crc_q   <= crc8_step(crc_q, shift_q[DATA_W-1]);
`endif
                    end
`ifdef SPI_REG_CRC_EN
                    // Writes compare the received byte; reads shift crc_q out on MISO.
                    CRC: if (sck_rise) begin
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        crc_rx_q  <= {crc_rx_q[5:0], mosi_s};
                        if (bit_cnt_q == BYTE_END) begin
                            bit_cnt_q <= '0;
                            state_q   <= DONE;
                            if (!rw_q) begin
                                if ({crc_rx_q, mosi_s} == crc_q) begin
                                    wr_reg_q  <= shift_q;
                                    wr_addr_q <= addr_q;
                                    chg_q     <= ~chg_q;
                                end else begin
                                    ferr_q <= 1'b1;
                                end
                            end
                        end
                    end else if (sck_fall && rw_q) begin
                        miso_q <= crc_q[7];
                        crc_q  <= {crc_q[6:0], 1'b0};
                    end
`endif
                    DONE: if (sck_fall) miso_q <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

    assign spi_miso       = miso_q;
    assign spi_miso_oe    = oe_q;
    assign wr_reg         = wr_reg_q;
    assign wr_reg_addr    = wr_addr_q;
    assign wr_reg_changed = chg_q;
    assign frame_err      = ferr_q;
endmodule
